display_pager: RTL

- Controller that shares the two-digit seven-segment display between the four bytes of a 32-bit status word (strobe count, FSM counters, encoder value).
- Selects one byte ("page") at a time and hands it to the digit decoders.
- Advances pages automatically every N shift strobes, or manually on a debounced key press.
- Holds a snapshot of the word so a page never tears while it is shown.

---
 rtl/display_pager.sv | 99 +++++++++
 1 files changed

// File: rtl/display_pager.sv
// display_pager - shares a two-digit display between the four bytes of a status word.
// Pages advance on a dwell count of strobes (AUTO) or on a step key edge (MANUAL).
module display_pager #(
  parameter int auto_dwell = 8,
  parameter int cnt_width  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        step,
  input  logic        mode_sel,
  input  logic        freeze,
  input  logic [31:0] data_in,
  output logic [7:0]  digit_out,
  output logic [1:0]  page,
  output logic [3:0]  dots,
  output logic        page_changed
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] AUTO   = 2'd1;
  localparam logic [1:0] MANUAL = 2'd2;

  localparam logic [cnt_width-1:0] DWELL_LAST = cnt_width'(auto_dwell - 1);

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [cnt_width-1:0] dwell;
  logic [cnt_width-1:0] dwell_nx;
  logic                 advance;
  logic                 step_prev;
  logic                 step_rise;
  logic [31:0]          snap;

  assign step_rise = step & ~step_prev;

  always_comb begin
    state_nx = state;
    dwell_nx = dwell;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (strobe) state_nx = mode_sel ? MANUAL : AUTO;
      end
      AUTO: begin
        // A key edge overrides and restarts the dwell; it never stacks with expiry.
        if (step_rise) begin
          advance  = 1'b1;
          dwell_nx = '0;
        end else if (strobe) begin
          if (dwell == DWELL_LAST) begin
            advance  = 1'b1;
            dwell_nx = '0;
          end else begin
            dwell_nx = dwell + cnt_width'(1);
          end
        end
        if (mode_sel) begin
          state_nx = MANUAL;
          dwell_nx = '0;
        end
      end
      MANUAL: begin
        dwell_nx = '0;
        advance  = step_rise;
        if (!mode_sel) state_nx = AUTO;
      end
      default: begin
        state_nx = IDLE;
        dwell_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      dwell        <= '0;
      step_prev    <= 1'b0;
      snap         <= '0;
      page         <= 2'd0;
      page_changed <= 1'b0;
      digit_out    <= 8'd0;
    end else begin
      state        <= state_nx;
      dwell        <= dwell_nx;
      step_prev    <= step;
      if (strobe && !freeze) snap <= data_in;
      page         <= page + {1'b0, advance};
      page_changed <= advance;
      digit_out    <= snap[{page, 3'b000} +: 8];
    end
  end

  always_comb begin
    dots = (state == IDLE) ? 4'b0000 : (4'b0001 << page);
  end

endmodule
